// File: rtl/sram_e_arbiter.sv
// sram_e_arbiter: arbitrates FC1 write, FC2 read and debug readback onto the five SRAM e banks
module sram_e_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  wr_req,
    input  logic [2:0]            wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [1:0]            wr_lane,
    input  logic [7:0]            wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_rvalid,
    input  logic                  dbg_req,
    input  logic [2:0]            dbg_bank,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [31:0]           dbg_rdata,
    input  logic [31:0]           sram_rdata_e0,
    input  logic [31:0]           sram_rdata_e1,
    input  logic [31:0]           sram_rdata_e2,
    input  logic [31:0]           sram_rdata_e3,
    input  logic [31:0]           sram_rdata_e4,
    output logic [ADDR_WIDTH-1:0] sram_raddr_e,
    output logic                  sram_write_enable_e0,
    output logic                  sram_write_enable_e1,
    output logic                  sram_write_enable_e2,
    output logic                  sram_write_enable_e3,
    output logic                  sram_write_enable_e4,
    output logic [3:0]            sram_bytemask_e,
    output logic [ADDR_WIDTH-1:0] sram_waddr_e,
    output logic [7:0]            sram_wdata_e,
    output logic                  bank_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    logic          force_dbg;
    logic [4:0]    we;
    logic          rd_v1, dbg_v1;
    logic [2:0]    dbg_bank1, dbg_bank2;
    assign force_dbg = starve_cnt == SW'(STARVE_LIMIT);
    assign wr_gnt  = srstn & wr_req & !force_dbg;
    assign rd_gnt  = srstn & rd_req & !wr_req & !force_dbg;
    assign dbg_gnt = srstn & dbg_req & (force_dbg | !(wr_req | rd_req));
    assign {sram_write_enable_e4, sram_write_enable_e3, sram_write_enable_e2,
            sram_write_enable_e1, sram_write_enable_e0} = we;
    // banks 5-7 shift the one-hot out of range, leaving every enable high
    assign dbg_rdata = !dbg_rvalid         ? '0 :
                       dbg_bank2 == 3'd0   ? sram_rdata_e0 :
                       dbg_bank2 == 3'd1   ? sram_rdata_e1 :
                       dbg_bank2 == 3'd2   ? sram_rdata_e2 :
                       dbg_bank2 == 3'd3   ? sram_rdata_e3 :
                       dbg_bank2 == 3'd4   ? sram_rdata_e4 : '0;
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            starve_cnt      <= '0;
            we              <= 5'h1F;
            sram_bytemask_e <= 4'hF;
            sram_waddr_e    <= '0;
            sram_wdata_e    <= '0;
            sram_raddr_e    <= '0;
            rd_v1           <= 1'b0;
            dbg_v1          <= 1'b0;
            dbg_bank1       <= '0;
            dbg_bank2       <= '0;
            rd_rvalid       <= 1'b0;
            dbg_rvalid      <= 1'b0;
            bank_err        <= 1'b0;
        end else begin
            starve_cnt      <= (dbg_req & !dbg_gnt) ? (force_dbg ? starve_cnt : starve_cnt + SW'(1)) : '0;
            we              <= wr_gnt ? ~(5'b1 << wr_bank) : 5'h1F;
            sram_bytemask_e <= wr_gnt ? ~(4'b1 << wr_lane) : 4'hF;
            if (wr_gnt) begin
                sram_waddr_e <= wr_addr;
                sram_wdata_e <= wr_data;
            end
            if (rd_gnt | dbg_gnt)
                sram_raddr_e <= rd_gnt ? rd_addr : dbg_addr;
            if (dbg_gnt)
                dbg_bank1 <= dbg_bank;
            rd_v1      <= rd_gnt;
            dbg_v1     <= dbg_gnt;
            dbg_bank2  <= dbg_bank1;
            rd_rvalid  <= rd_v1;
            dbg_rvalid <= dbg_v1;
            if ((wr_gnt && wr_bank > 3'd4) || (dbg_gnt && dbg_bank > 3'd4))
                bank_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_e_arbiter.sv
// tb_sram_e_arbiter: directed checks of sram_e_arbiter against a behavioural five-bank SRAM e model
module tb_sram_e_arbiter;
    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0, dbg_req = 1'b0;
    logic [2:0]  wr_bank = '0, dbg_bank = '0;
    logic [9:0]  wr_addr = '0, rd_addr = '0, dbg_addr = '0;
    logic [1:0]  wr_lane = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_gnt, rd_gnt, rd_rvalid, dbg_gnt, dbg_rvalid, bank_err;
    logic [31:0] dbg_rdata;
    logic [31:0] rdat [5];
    logic [9:0]  sram_raddr_e, sram_waddr_e;
    logic        we0, we1, we2, we3, we4;
    logic [4:0]  we;
    logic [3:0]  sram_bytemask_e;
    logic [7:0]  sram_wdata_e;
    logic [31:0] mem [5][1024];
    int          checks = 0, failures = 0;

    sram_e_arbiter dut (
        .clk(clk), .srstn(srstn),
        .wr_req(wr_req), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
        .dbg_req(dbg_req), .dbg_bank(dbg_bank), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .sram_rdata_e0(rdat[0]), .sram_rdata_e1(rdat[1]), .sram_rdata_e2(rdat[2]),
        .sram_rdata_e3(rdat[3]), .sram_rdata_e4(rdat[4]),
        .sram_raddr_e(sram_raddr_e),
        .sram_write_enable_e0(we0), .sram_write_enable_e1(we1), .sram_write_enable_e2(we2),
        .sram_write_enable_e3(we3), .sram_write_enable_e4(we4),
        .sram_bytemask_e(sram_bytemask_e), .sram_waddr_e(sram_waddr_e), .sram_wdata_e(sram_wdata_e),
        .bank_err(bank_err)
    );

    assign we = {we4, we3, we2, we1, we0};
    always #5 clk = ~clk;

    // synchronous-read SRAM: address in one cycle, data the next; byte writes under active-low mask
    always @(posedge clk) begin
        for (int b = 0; b < 5; b++) begin
            for (int l = 0; l < 4; l++)
                if (!we[b] && !sram_bytemask_e[l]) mem[b][sram_waddr_e][l*8 +: 8] <= sram_wdata_e;
            rdat[b] <= mem[b][sram_raddr_e];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int b = 0; b < 5; b++) begin
            rdat[b] = '0;
            for (int a = 0; a < 1024; a++) mem[b][a] = '0;
        end
        // reset state, with requests present to show grants are held off
        wr_req = 1'b1; rd_req = 1'b1; dbg_req = 1'b1;
        tick(); tick();
        check("rst_wr_gnt", wr_gnt, 0);
        check("rst_rd_gnt", rd_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_we", we, 5'h1F);
        check("rst_mask", sram_bytemask_e, 4'hF);
        check("rst_raddr", sram_raddr_e, 0);
        check("rst_waddr", sram_waddr_e, 0);
        check("rst_wdata", sram_wdata_e, 0);
        check("rst_rvalids", {rd_rvalid, dbg_rvalid}, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_bank_err", bank_err, 0);
        wr_req = 1'b0; rd_req = 1'b0; dbg_req = 1'b0;
        srstn = 1'b1;
        tick();

        // single byte write, bank 2 lane 1
        wr_req = 1'b1; wr_bank = 3'd2; wr_addr = 10'h005; wr_lane = 2'd1; wr_data = 8'h7A;
        #1 check("w_gnt", wr_gnt, 1);
        check("w_rd_gnt", rd_gnt, 0);
        tick(); wr_req = 1'b0;
        check("w_we", we, 5'b11011);
        check("w_mask", sram_bytemask_e, 4'b1101);
        check("w_waddr", sram_waddr_e, 10'h005);
        check("w_wdata", sram_wdata_e, 8'h7A);
        tick();
        check("w_idle_we", we, 5'h1F);
        check("w_idle_mask", sram_bytemask_e, 4'hF);
        check("w_hold_waddr", sram_waddr_e, 10'h005);
        check("w_hold_wdata", sram_wdata_e, 8'h7A);

        // write and read together; read of the same address sees the new byte
        wr_req = 1'b1; wr_bank = 3'd0; wr_addr = 10'h020; wr_lane = 2'd0; wr_data = 8'h11;
        rd_req = 1'b1; rd_addr = 10'h020;
        #1 check("wr_first_wgnt", wr_gnt, 1);
        check("wr_first_rgnt", rd_gnt, 0);
        tick(); wr_req = 1'b0;
        #1 check("rd_second_gnt", rd_gnt, 1);
        check("rd_second_rv", rd_rvalid, 0);
        tick(); rd_req = 1'b0;
        check("rd_raddr", sram_raddr_e, 10'h020);
        check("rd_t1_rv", rd_rvalid, 0);
        tick();
        check("rd_t2_rv", rd_rvalid, 1);
        check("rd_t2_data", rdat[0], 32'h0000_0011);
        tick();
        check("rd_t3_rv", rd_rvalid, 0);

        // write bank 3 then debug readback of it the following cycle
        wr_req = 1'b1; wr_bank = 3'd3; wr_addr = 10'h010; wr_lane = 2'd2; wr_data = 8'hC3;
        #1 check("dw_wgnt", wr_gnt, 1);
        tick(); wr_req = 1'b0;
        dbg_req = 1'b1; dbg_bank = 3'd3; dbg_addr = 10'h010;
        #1 check("dw_dgnt", dbg_gnt, 1);
        tick(); dbg_req = 1'b0;
        check("dw_t1_rv", dbg_rvalid, 0);
        tick();
        check("dw_t2_rv", dbg_rvalid, 1);
        check("dw_t2_data", dbg_rdata, 32'h00C3_0000);
        tick();
        check("dw_t3_rv", dbg_rvalid, 0);
        check("dw_t3_data", dbg_rdata, 0);

        // starvation: debug wins on the ninth consecutive cycle against a constant writer
        wr_req = 1'b1; wr_bank = 3'd1; wr_addr = 10'h030; wr_lane = 2'd3; wr_data = 8'h55;
        dbg_req = 1'b1; dbg_bank = 3'd3; dbg_addr = 10'h010;
        for (int i = 1; i <= 9; i++) begin
            #1 check($sformatf("starve_dgnt_%0d", i), dbg_gnt, (i == 9));
            check($sformatf("starve_wgnt_%0d", i), wr_gnt, (i != 9));
            tick();
        end
        #1 check("starve_after_dgnt", dbg_gnt, 0);
        check("starve_after_wgnt", wr_gnt, 1);
        tick(); wr_req = 1'b0; dbg_req = 1'b0;
        check("starve_rv", dbg_rvalid, 1);
        check("starve_data", dbg_rdata, 32'h00C3_0000);
        tick();

        // debug request to nonexistent bank 6
        dbg_req = 1'b1; dbg_bank = 3'd6; dbg_addr = 10'h010;
        #1 check("b6_dgnt", dbg_gnt, 1);
        tick(); dbg_req = 1'b0;
        check("b6_err", bank_err, 1);
        check("b6_we", we, 5'h1F);
        tick();
        check("b6_rv", dbg_rvalid, 1);
        check("b6_data", dbg_rdata, 0);
        tick(); tick();
        check("b6_err_sticky", bank_err, 1);

        // reset lands one cycle after a read grant; the read never returns
        rd_req = 1'b1; rd_addr = 10'h020;
        #1 check("rr_gnt", rd_gnt, 1);
        tick(); rd_req = 1'b0;
        check("rr_raddr", sram_raddr_e, 10'h020);
        srstn = 1'b0;
        #1 check("rr_rst_raddr", sram_raddr_e, 0);
        check("rr_rst_err", bank_err, 0);
        check("rr_rst_waddr", sram_waddr_e, 0);
        check("rr_rst_wdata", sram_wdata_e, 0);
        tick();
        check("rr_rst_rv", rd_rvalid, 0);
        srstn = 1'b1;
        tick();
        check("rr_post_rv", rd_rvalid, 0);
        tick();
        check("rr_post_rv2", rd_rvalid, 0);
        check("rr_post_we", we, 5'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
